// File: rtl/io_cmd_initiator.sv
// Initiator side of the IO command interface: accepts one command, strobes it to the
// IO block, waits for rdy or a timeout, then returns the response over valid/ready.
module io_cmd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_cmd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [23:0] resp_data,
    output logic        resp_err,
    output logic        busy,
    output logic        io_start,
    output logic [23:0] io_in,
    input  logic        io_rdy,
    input  logic [23:0] io_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            io_start   <= 1'b0;
            io_in      <= '0;
        end else begin
            io_start <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        state     <= ISSUE;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        io_start  <= 1'b1;
                        io_in     <= req_cmd;
                        cnt       <= '0;
                    end
                end
                // cnt counts cycles since ISSUE, so the ISSUE cycle itself is included
                // and the terminal value lands TIMEOUT_CYCLES cycles after ISSUE.
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= cnt + CNT_W'(1);
                end
                WAIT: begin
                    if (io_rdy) begin
                        resp_data  <= io_out;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (cnt == TERM) begin
                        resp_data  <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        io_in      <= '0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_cmd_initiator.sv
// Bench for io_cmd_initiator: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_io_cmd_initiator;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b0;
    logic        io_rdy = 1'b0;
    logic [23:0] req_cmd = '0;
    logic [23:0] io_out = '0;
    logic        req_ready, resp_valid, resp_err, busy, io_start;
    logic [23:0] resp_data, io_in;

    int n_checks = 0;
    int n_pass   = 0;

    io_cmd_initiator #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
        .io_start(io_start), .io_in(io_in), .io_rdy(io_rdy), .io_out(io_out)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
    endtask

    task automatic check24(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    endtask

    // Model: a transaction is described by the edge it was accepted at; the response
    // becomes due on the first in-window rdy or once T cycles have followed ISSUE.
    bit          m_active, m_done, m_ready, m_err;
    int          m_edge, m_acc;
    logic [23:0] m_cmd, m_data;

    always @(posedge clk or negedge rst) begin : model
        int k;
        if (!rst) begin
            m_active = 0; m_done = 0; m_ready = 0; m_err = 0;
            m_edge = 0; m_acc = 0; m_cmd = '0; m_data = '0;
        end else begin
            m_edge++;
            k = m_edge - m_acc;
            if (!m_active) begin
                if (m_ready && req_valid) begin
                    m_active = 1; m_done = 0; m_acc = m_edge; m_cmd = req_cmd;
                end
            end else if (!m_done) begin
                if (k >= 2 && io_rdy) begin
                    m_done = 1; m_data = io_out; m_err = 0;
                end else if (k == T) begin
                    m_done = 1; m_data = '0; m_err = 1;
                end
            end else if (resp_ready) begin
                m_active = 0;
            end
            m_ready = !m_active;
        end
    end

    always @(negedge clk) begin
        check1("req_ready", req_ready, m_ready);
        check1("busy", busy, m_active);
        check1("io_start", io_start, m_active && (m_edge == m_acc));
        check24("io_in", io_in, m_active ? m_cmd : 24'h0);
        check1("resp_valid", resp_valid, m_active && m_done);
        if (m_active && m_done) begin
            check24("resp_data", resp_data, m_data);
            check1("resp_err", resp_err, m_err);
        end
    end

    // IO block stand-in: pulses rdy a programmed number of cycles after io_start,
    // or randomly in mode 2.
    int          rsp_mode = 0;
    int          rsp_d1 = -1;
    int          rsp_d2 = -1;
    int          since = -1;
    logic [23:0] rsp_word = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (io_start) since = 0;
            else if (since >= 0) since++;
            #1;
            io_rdy = 1'b0;
            if (rsp_mode == 2) begin
                io_rdy = ($urandom_range(3) == 0);
                io_out = 24'($urandom);
            end else if (rsp_mode == 1 && since >= 0) begin
                if (since == rsp_d1) begin
                    io_rdy = 1'b1; io_out = rsp_word;
                end else if (since == rsp_d2) begin
                    io_rdy = 1'b1; io_out = 24'($urandom);
                end
            end
        end
    end

    task automatic send(input logic [23:0] cmd, input bit keep);
        #1;
        req_valid = 1'b1;
        req_cmd   = cmd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (io_start) break;
        end
        check1("io_start_seen", io_start, 1'b1);
        check24("io_in_at_start", io_in, cmd);
        if (!keep) begin
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        check1("resp_seen", resp_valid, 1'b1);
    endtask

    task automatic consume();
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        // Reset with a pending request
        #1;
        rst       = 1'b0;
        req_valid = 1'b1;
        req_cmd   = 24'h777777;
        repeat (3) @(negedge clk);
        check1("rst_req_ready", req_ready, 1'b0);
        check1("rst_resp_valid", resp_valid, 1'b0);
        check1("rst_io_start", io_start, 1'b0);
        check24("rst_io_in", io_in, 24'h0);
        check24("rst_resp_data", resp_data, 24'h0);
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check1("req_ready_after_rst", req_ready, 1'b1);
        repeat (2) @(negedge clk);
        check1("no_start_idle", io_start, 1'b0);

        // Normal transaction, response 4 cycles after io_start
        rsp_mode = 1; rsp_d1 = 4; rsp_d2 = -1; rsp_word = 24'hABCDEF;
        send(24'h123456, 0);
        @(negedge clk);
        check1("io_start_one_cycle", io_start, 1'b0);
        wait_resp(lat);
        check_int("normal_latency", lat + 1, 5);
        check24("normal_data", resp_data, 24'hABCDEF);
        check1("normal_err", resp_err, 1'b0);
        consume();

        // Silent IO block -> timeout T cycles after ISSUE
        rsp_mode = 0;
        send(24'h0BAD01, 0);
        wait_resp(lat);
        check_int("timeout_latency", lat, T);
        check1("timeout_err", resp_err, 1'b1);
        check24("timeout_data", resp_data, 24'h0);
        consume();

        // Stray rdy in the ISSUE cycle, real rdy later
        rsp_mode = 1; rsp_d1 = 3; rsp_d2 = 0; rsp_word = 24'h5A5A5A;
        send(24'h000111, 0);
        wait_resp(lat);
        check_int("stray_latency", lat, 4);
        check24("stray_data", resp_data, 24'h5A5A5A);
        check1("stray_err", resp_err, 1'b0);
        consume();

        // rdy coincident with terminal count wins
        rsp_d1 = T - 1; rsp_d2 = -1; rsp_word = 24'h0F1E2D;
        send(24'h000222, 0);
        wait_resp(lat);
        check_int("race_latency", lat, T);
        check24("race_data", resp_data, 24'h0F1E2D);
        check1("race_err", resp_err, 1'b0);
        consume();

        // rdy one cycle too late -> timeout, late strobe discarded
        rsp_d1 = T; rsp_word = 24'h333333;
        send(24'h000333, 0);
        wait_resp(lat);
        check_int("late_latency", lat, T);
        check1("late_err", resp_err, 1'b1);
        check24("late_data", resp_data, 24'h0);
        consume();

        // Backpressure with a second request waiting
        rsp_d1 = 2; rsp_word = 24'h112233;
        send(24'h000444, 1);
        wait_resp(lat);
        check_int("bp_latency", lat, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check1("bp_resp_valid", resp_valid, 1'b1);
            check24("bp_resp_data", resp_data, 24'h112233);
            check1("bp_req_ready", req_ready, 1'b0);
            check1("bp_no_start", io_start, 1'b0);
        end
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (io_start) break;
        end
        check1("bp_second_start", io_start, 1'b1);
        check24("bp_second_io_in", io_in, 24'h000444);
        #1;
        req_valid = 1'b0;
        wait_resp(lat);
        consume();

        // Reset in WAIT, late rdy afterwards must not produce a response
        rsp_d1 = 6; rsp_word = 24'h666666;
        send(24'h000555, 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_resp_valid", resp_valid, 1'b0);
        check24("midrst_io_in", io_in, 24'h0);
        check1("midrst_req_ready", req_ready, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check1("midrst_no_resp", resp_valid, 1'b0);
        end

        // Randomized traffic
        rsp_mode = 2;
        for (int i = 0; i < 500; i++) begin
            #1;
            req_valid  = 1'($urandom_range(1));
            req_cmd    = 24'($urandom);
            resp_ready = ($urandom_range(2) != 0);
            @(negedge clk);
        end
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
